buffer_drain_ctrl: RTL and testbench
====================================

// Module: buffer_drain_ctrl
// PURPOSE
//  Downstream read stage of the router input Buffer. Issues Buffer remove requests in FIFO order and
//  completes the remove/remove_finish four-phase handshake. Presents each removed flit to the switch
//  stage on a registered valid/ready port. Tracks the Buffer read index itself and flags handshake
//  timeouts.
// PARAMETERS
//  ADDR_W   8   Buffer index width; index arithmetic is modulo 2**ADDR_W
//  WIDTH    30  flit width, equal to the Buffer width
//  TIMEOUT  16  cycles allowed per handshake phase before abort (must be >= 2)
// PORTS
//  clk              in   1       rising-edge clock
//  rst              in   1       synchronous, active-high reset
//  en               in   1       when low, no new remove starts; an in-flight handshake still completes
//  buf_empty        in   1       Buffer empty flag
//  buf_out          in   WIDTH   Buffer out; valid while buf_remove_finish=1
//  buf_remove_finish in  1       Buffer remove_finish
//  buf_remove       out  1       Buffer remove request (level)
//  buf_index        out  ADDR_W  Buffer index; always equals rd_idx
//  flit_out         out  WIDTH   flit to switch stage
//  flit_valid       out  1       flit_out valid
//  flit_ready       in   1       switch stage accepts flit_out this cycle
//  drained_cnt      out  16      number of flits captured, wraps at 2**16
//  err_timeout      out  1       sticky; set when a handshake phase aborts
// BEHAVIOUR
//  - All inputs are sampled on posedge clk. The block has no combinational input->output path.
//  - Reset values: buf_remove=0, rd_idx=0 (so buf_index=0), flit_out=0, flit_valid=0,
//    drained_cnt=0, err_timeout=0, state=IDLE, tmo_cnt=0.
//  - Reset mid-handshake drops buf_remove in the next cycle. The Buffer is not re-synchronised.
//  - FSM states: IDLE, REQ, REL.
//    IDLE -> REQ when en & ~buf_empty & slot_free. On entry, buf_remove=1 and tmo_cnt=0.
//      slot_free = ~flit_valid | flit_ready.
//    REQ -> REL when buf_remove_finish=1. On that edge:
//      flit_out<=buf_out, flit_valid<=1, buf_remove<=0, rd_idx<=rd_idx+1 (wraps),
//      drained_cnt<=drained_cnt+1.
//    REL -> IDLE when buf_remove_finish=0.
//  - Timeout: tmo_cnt counts cycles in REQ and REL and resets on each state entry.
//    In REQ, reaching TIMEOUT with no finish:
//      buf_remove<=0, err_timeout<=1, go to REL; rd_idx and flit_valid unchanged (no capture).
//    In REL, reaching TIMEOUT with finish still high: err_timeout<=1, go to IDLE.
//  - Output port:
//    flit_valid & flit_ready clears flit_valid, unless a capture occurs on the same edge;
//      then flit_valid stays 1 and flit_out takes the new flit.
//    flit_out is held stable while flit_valid & ~flit_ready.
//  - Throughput: at most one flit per 3 cycles (IDLE->REQ->REL->IDLE) with a single-cycle finish response.
//  - Latency:
//    From buf_empty falling (slot free, en=1), buf_remove rises 1 cycle later.
//    flit_valid rises on the edge that samples finish=1.
//  - rd_idx wraps from 2**ADDR_W-1 to 0, mirroring Buffer rd_ptr.
//  - buf_empty=1 while in REQ/REL is ignored; the handshake completes.
//  - en low only gates the IDLE->REQ transition.
// TESTING
//  1 Reset: hold rst 2 cycles -> all outputs at reset values, buf_index=0.
//  2 Single flit: buf_empty=0, buf_out=30'h0ABCDEF, finish model rises 1 cycle after remove and
//    falls 1 cycle after remove drops, flit_ready=1 ->
//    flit_out=30'h0ABCDEF with one flit_valid pulse, buf_index 0->1, drained_cnt=1.
//  3 Backpressure: 3 flits 1,2,3 queued, flit_ready=0 for 10 cycles then 1 ->
//    only flit 1 is removed while stalled, flit_out is stable, then flits 2 and 3 follow in order.
//  4 Wrap: ADDR_W=2, drain 5 flits -> buf_index sequence 0,1,2,3,0,1.
//  5 Timeout: finish held 0 after remove, TIMEOUT=16 ->
//    buf_remove drops at 16 cycles, err_timeout=1, buf_index unchanged, no flit_valid.
//  6 Reset mid-REQ: assert rst while buf_remove=1 ->
//    buf_remove=0 next cycle, state IDLE, drained_cnt=0.

Source files
------------

// File: rtl/buffer_drain_if.sv
// Buffer-side remove handshake and switch-side flit port of the input-buffer read stage.
// master = drain controller, slave = Buffer/switch environment.
interface buffer_drain_if #(
  parameter int ADDR_W = 8,
  parameter int WIDTH  = 30
);
  logic              buf_empty;
  logic [WIDTH-1:0]  buf_out;
  logic              buf_remove_finish;
  logic              buf_remove;
  logic [ADDR_W-1:0] buf_index;
  logic [WIDTH-1:0]  flit_out;
  logic              flit_valid;
  logic              flit_ready;

  modport master (
    input  buf_empty, buf_out, buf_remove_finish, flit_ready,
    output buf_remove, buf_index, flit_out, flit_valid
  );
  modport slave (
    output buf_empty, buf_out, buf_remove_finish, flit_ready,
    input  buf_remove, buf_index, flit_out, flit_valid
  );
endinterface

// File: rtl/buffer_drain_ctrl.sv
// Router input-buffer read stage: four-phase remove handshake in FIFO order,
// registered valid/ready flit output, local read index and sticky timeout flag.
module buffer_drain_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int WIDTH   = 30,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  buffer_drain_if.master bus,
  output logic [15:0]   drained_cnt,
  output logic          err_timeout
);
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;

  state_t            r_state, w_next;
  logic [TW-1:0]     r_tmo;
  logic              r_remove;
  logic [ADDR_W-1:0] r_rd_idx;
  logic [WIDTH-1:0]  r_flit;
  logic              r_valid;
  logic [15:0]       r_cnt;
  logic              r_err;

  logic w_slot_free, w_tmo_hit, w_start, w_capture, w_abort_req, w_abort_rel;

  assign w_slot_free = ~r_valid | bus.flit_ready;
  // Each phase gets exactly TIMEOUT sampled cycles before aborting.
  assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT - 1));

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_abort_req = 1'b0;
    w_abort_rel = 1'b0;
    case (r_state)
      S_IDLE: if (en && !bus.buf_empty && w_slot_free) begin
        w_next  = S_REQ;
        w_start = 1'b1;
      end
      S_REQ: if (bus.buf_remove_finish) begin
        w_next    = S_REL;
        w_capture = 1'b1;
      end else if (w_tmo_hit) begin
        w_next      = S_REL;
        w_abort_req = 1'b1;
      end
      S_REL: if (!bus.buf_remove_finish) begin
        w_next = S_IDLE;
      end else if (w_tmo_hit) begin
        w_next      = S_IDLE;
        w_abort_rel = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_tmo    <= '0;
      r_remove <= 1'b0;
      r_rd_idx <= '0;
      r_flit   <= '0;
      r_valid  <= 1'b0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state != w_next)     r_tmo <= '0;
      else if (r_state != S_IDLE) r_tmo <= r_tmo + 1'b1;

      if (w_start)                       r_remove <= 1'b1;
      else if (w_capture || w_abort_req) r_remove <= 1'b0;

      // A capture on the same edge as an accept keeps valid high with the new flit.
      if (w_capture) begin
        r_flit   <= bus.buf_out;
        r_valid  <= 1'b1;
        r_rd_idx <= r_rd_idx + 1'b1;
        r_cnt    <= r_cnt + 1'b1;
      end else if (r_valid && bus.flit_ready) begin
        r_valid <= 1'b0;
      end

      if (w_abort_req || w_abort_rel) r_err <= 1'b1;
    end
  end

  assign bus.buf_remove = r_remove;
  assign bus.buf_index  = r_rd_idx;
  assign bus.flit_out   = r_flit;
  assign bus.flit_valid = r_valid;
  assign drained_cnt    = r_cnt;
  assign err_timeout    = r_err;
endmodule

// File: tb/tb_buffer_drain_ctrl.sv
// Bench for buffer_drain_ctrl: Buffer/switch environment model with a transaction-level
// scoreboard, directed scenarios and a randomized traffic phase.
module tb_buffer_drain_ctrl;
  localparam int AW  = 2;
  localparam int W   = 30;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] drained_cnt;
  logic        err_timeout;

  always #5 clk = ~clk;

  buffer_drain_if #(.ADDR_W(AW), .WIDTH(W)) bif();

  buffer_drain_ctrl #(.ADDR_W(AW), .WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .bus         (bif),
    .drained_cnt (drained_cnt),
    .err_timeout (err_timeout)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] bq[$];
  logic [W-1:0] pushed_q[$];
  logic [W-1:0] acc_q[$];

  logic         m_valid, m_err, rose, no_resp;
  logic [W-1:0] m_flit;
  int           m_idx, m_cnt, rq_cnt, cyc, last_rise;
  int           rwait, rhold, rdelay, hdelay, rdly_max, hold_max;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input logic [W-1:0] v);
    bq.push_back(v);
    pushed_q.push_back(v);
    bif.buf_empty = 1'b0;
  endtask

  // One clock: note what the DUT will sample, advance to the negedge, update the
  // scoreboard from the handshake that just happened, check, then drive the environment.
  task automatic step();
    logic p_rm, p_fin, p_rdy, p_en, p_emp, p_rst, p_mv, p_slot, cap, ok;
    p_rm  = bif.buf_remove;
    p_fin = bif.buf_remove_finish;
    p_rdy = bif.flit_ready;
    p_en  = en;
    p_emp = bif.buf_empty;
    p_rst = rst;
    p_mv  = m_valid;
    p_slot = !p_mv || p_rdy;
    if (!p_rst && p_mv && p_rdy) acc_q.push_back(bif.flit_out);
    @(negedge clk);
    cyc++;
    rose = 1'b0;
    if (p_rst) begin
      m_valid = 1'b0; m_flit = '0; m_idx = 0; m_cnt = 0; m_err = 1'b0;
      rq_cnt = 0; last_rise = -100;
      chk("rst_remove", 32'(bif.buf_remove), 0);
      chk("rst_flit", 32'(bif.flit_out), 0);
    end else begin
      cap = p_rm && p_fin;
      if (p_mv && p_rdy) m_valid = 1'b0;
      if (cap) begin
        chk("cap_nonempty", 32'(bq.size() > 0), 1);
        if (bq.size() > 0) m_flit = bq.pop_front();
        m_valid = 1'b1;
        m_idx   = (m_idx + 1) % (1 << AW);
        m_cnt   = (m_cnt + 1) % 65536;
      end
      if (!p_rm) rq_cnt = 0;
      else if (!p_fin) begin
        rq_cnt++;
        if (rq_cnt == TMO) begin
          m_err = 1'b1;
          chk("tmo_remove_drop", 32'(bif.buf_remove), 0);
        end
      end
      if (bif.buf_remove && !p_rm) begin
        rose = 1'b1;
        ok = p_en && !p_emp && p_slot && (cyc - last_rise >= 3);
        chk("start_legal", 32'(ok), 1);
        last_rise = cyc;
      end
    end
    chk("buf_index", 32'(bif.buf_index), 32'(m_idx));
    chk("drained_cnt", 32'(drained_cnt), 32'(m_cnt));
    chk("flit_valid", 32'(bif.flit_valid), 32'(m_valid));
    if (m_valid) chk("flit_out", 32'(bif.flit_out), 32'(m_flit));
    chk("err_timeout", 32'(err_timeout), 32'(m_err));

    // Buffer responder: finish follows remove after a delay, drops after remove releases.
    if (bif.buf_remove && !bif.buf_remove_finish) begin
      if (!no_resp) begin
        if (rwait >= rdelay) begin
          bif.buf_remove_finish = 1'b1;
          bif.buf_out = (bq.size() > 0) ? bq[0] : '0;
        end else rwait++;
      end
    end else if (bif.buf_remove_finish && !bif.buf_remove) begin
      if (rhold >= hdelay) begin
        bif.buf_remove_finish = 1'b0;
        bif.buf_out = W'($urandom);
        rwait = 0; rhold = 0;
        rdelay = $urandom_range(0, rdly_max);
        hdelay = $urandom_range(0, hold_max);
      end else rhold++;
    end
    bif.buf_empty = (bq.size() == 0);
  endtask

  initial begin
    int n, k, vcount;
    int exp_seq[5];
    logic [31:0] idxs[5];
    exp_seq = '{0, 1, 2, 3, 0};
    rst = 1'b1; en = 1'b0; no_resp = 1'b0;
    bif.buf_empty = 1'b1; bif.buf_out = '0; bif.buf_remove_finish = 1'b0; bif.flit_ready = 1'b0;
    rwait = 0; rhold = 0; rdelay = 0; hdelay = 0; rdly_max = 0; hold_max = 0;
    m_valid = 1'b0; m_err = 1'b0; m_flit = '0; m_idx = 0; m_cnt = 0; rq_cnt = 0;
    cyc = 0; last_rise = -100; rose = 1'b0;

    // Reset held two cycles
    step(); step();
    rst = 1'b0;
    step();

    // Single flit, minimum-latency responder
    en = 1'b1; bif.flit_ready = 1'b1;
    push(30'h0ABCDEF);
    step();
    chk("t2_latency", 32'(rose), 1);
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) chk("t2_flit", 32'(bif.flit_out), 32'h0ABCDEF);
      vcount += int'(bif.flit_valid);
    end
    chk("t2_pulses", 32'(vcount), 1);
    chk("t2_index", 32'(bif.buf_index), 1);
    chk("t2_cnt", 32'(drained_cnt), 1);

    // Backpressure: only the first flit leaves the Buffer while stalled
    pushed_q.delete(); acc_q.delete();
    bif.flit_ready = 1'b0;
    push(30'd1); push(30'd2); push(30'd3);
    for (int i = 0; i < 10; i++) step();
    chk("t3_stall_cnt", 32'(drained_cnt), 2);
    chk("t3_stall_flit", 32'(bif.flit_out), 1);
    chk("t3_stall_left", 32'(bq.size()), 2);
    bif.flit_ready = 1'b1;
    for (int i = 0; i < 60 && acc_q.size() < 3; i++) step();
    chk("t3_acc_n", 32'(acc_q.size()), 3);
    for (int i = 0; i < acc_q.size() && i < 3; i++) chk("t3_order", 32'(acc_q[i]), 32'(i + 1));

    // Index wrap across five flits with varied responder timing
    rdly_max = 2; hold_max = 1;
    for (int i = 0; i < 5; i++) push(W'($urandom));
    k = 0;
    for (int i = 0; i < 100 && k < 5; i++) begin
      step();
      if (rose) begin idxs[k] = 32'(bif.buf_index); k++; end
    end
    chk("t4_rises", 32'(k), 5);
    for (int i = 0; i < k; i++) chk("t4_index_seq", idxs[i], 32'(exp_seq[i]));
    for (int i = 0; i < 10; i++) step();
    chk("t4_index_end", 32'(bif.buf_index), 1);

    // Remove phase timeout
    no_resp = 1'b1;
    push(30'h155);
    for (int i = 0; i < 10 && !rose; i++) step();
    chk("t5_rise", 32'(rose), 1);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!bif.buf_remove) break;
      n++;
    end
    en = 1'b0;
    chk("t5_len", 32'(n), TMO);
    chk("t5_err", 32'(err_timeout), 1);
    chk("t5_index", 32'(bif.buf_index), 1);
    chk("t5_valid", 32'(bif.flit_valid), 0);
    for (int i = 0; i < 3; i++) step();

    // Reset while remove is asserted
    en = 1'b1;
    rose = 1'b0;
    for (int i = 0; i < 10 && !bif.buf_remove; i++) step();
    chk("t6_in_req", 32'(bif.buf_remove), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bq.delete();
    bif.buf_empty = 1'b1;
    step();
    chk("t6_remove", 32'(bif.buf_remove), 0);
    chk("t6_cnt", 32'(drained_cnt), 0);
    chk("t6_err", 32'(err_timeout), 0);

    // Randomized traffic against the scoreboard
    no_resp = 1'b0;
    pushed_q.delete(); acc_q.delete();
    for (int i = 0; i < 500; i++) begin
      en = ($urandom_range(0, 9) < 8);
      bif.flit_ready = ($urandom_range(0, 9) < 7);
      if (bq.size() < 5 && $urandom_range(0, 9) < 4) push(W'($urandom));
      step();
    end
    en = 1'b1; bif.flit_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (bq.size() == 0 && !m_valid && !bif.buf_remove && !bif.buf_remove_finish) break;
      step();
    end
    chk("t7_acc_n", 32'(acc_q.size()), 32'(pushed_q.size()));
    for (int i = 0; i < acc_q.size() && i < pushed_q.size(); i++)
      chk("t7_order", 32'(acc_q[i]), 32'(pushed_q[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
